// File: rtl/bus_pkg.sv
// Shared definitions for the 16A/16D serial register bus: command codes,
// slot geometry, response codes and the initiator state set.
package bus_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    localparam int unsigned SLOT_BITS  = 13;
    localparam int unsigned FRAME_BITS = 12;
    localparam int unsigned WR_SLOTS   = 5;
    localparam int unsigned RD_SLOTS   = 3;
    localparam int unsigned MSG_BITS   = WR_SLOTS * SLOT_BITS;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_TIMEOUT = 2'd1;
    localparam logic [1:0] RSP_PROTO   = 2'd2;

    typedef enum logic [2:0] {
        ST_QUIET,
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RESP
    } state_e;

    // One slot, MSb first: idle 0, start 1, flag, data byte, two stop zeros.
    function automatic logic [SLOT_BITS-1:0] make_slot(input logic flag, input logic [7:0] data);
        return {1'b0, 1'b1, flag, data, 2'b00};
    endfunction

endpackage

// File: rtl/bus_deframer.sv
// Serial-bus byte deframer: shifts the line into a 12-bit window and reports
// a byte when a complete start/flag/data/stop frame is aligned in it.
module bus_deframer
    import bus_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       serialin,
    output logic       byte_valid,
    output logic       byte_flag,
    output logic [7:0] byte_data
);

    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] shift_d;

    always_comb begin
        byte_valid = shift_q[FRAME_BITS-1] && (shift_q[1:0] == 2'b00);
        byte_flag  = shift_q[FRAME_BITS-2];
        byte_data  = shift_q[FRAME_BITS-3:2];
        shift_d    = {shift_q[FRAME_BITS-2:0], serialin};
        // Emptying the window after a hit keeps the next frame's start bit aligned.
        if (clear || byte_valid) begin
            shift_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: rtl/bus_initiator.sv
// Host-side initiator: accepts one register request, sends it as framed
// slots on serialout, then parses the target's reply into data or an error.
module bus_initiator
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned QUIET   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wrdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rddata,
    output logic [1:0]  rsp_err,
    output logic        busy,
    output logic        serialout,
    input  logic        serialin
);

    localparam int unsigned RD_BITS = RD_SLOTS * SLOT_BITS;
    localparam int unsigned CNT_A   = (TIMEOUT > QUIET) ? TIMEOUT : QUIET;
    localparam int unsigned CNT_MAX = (CNT_A > MSG_BITS) ? CNT_A : MSG_BITS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MSG_BITS-1:0] tx_q, tx_d;
    logic [MSG_BITS-1:0] msg;
    logic                wr_q, wr_d;
    logic [15:0]         acc_q, acc_d;
    logic [1:0]          rxcnt_q, rxcnt_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                busy_q, busy_d;
    logic                serialout_q, serialout_d;
    logic [15:0]         rsp_rddata_q, rsp_rddata_d;
    logic [1:0]          rsp_err_q, rsp_err_d;

    logic [CNT_W-1:0]    tx_len;
    logic                cmd_ok;
    logic                rx_clear;
    logic                byte_valid;
    logic                byte_flag;
    logic [7:0]          byte_data;

    assign rx_clear = rst || (state_q == ST_IDLE);

    bus_deframer u_deframer (
        .clk        (clk),
        .clear      (rx_clear),
        .serialin   (serialin),
        .byte_valid (byte_valid),
        .byte_flag  (byte_flag),
        .byte_data  (byte_data)
    );

    always_comb begin
        if (req_wr) begin
            msg = {make_slot(1'b0, req_wrdata[15:8]), make_slot(1'b0, req_wrdata[7:0]),
                   make_slot(1'b0, req_addr[15:8]),   make_slot(1'b0, req_addr[7:0]),
                   make_slot(1'b1, CMD_WRITE)};
        end else begin
            msg = {make_slot(1'b0, req_addr[15:8]), make_slot(1'b0, req_addr[7:0]),
                   make_slot(1'b1, CMD_READ), {(MSG_BITS - RD_BITS){1'b0}}};
        end
    end

    assign tx_len = wr_q ? CNT_W'(MSG_BITS) : CNT_W'(RD_BITS);
    assign cmd_ok = wr_q ? ((byte_data == CMD_WRITE) && (rxcnt_q == 2'd0))
                         : ((byte_data == CMD_READ)  && (rxcnt_q == 2'd2));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_d         = tx_q;
        wr_d         = wr_q;
        acc_d        = acc_q;
        rxcnt_d      = rxcnt_q;
        req_ready_d  = 1'b0;
        rsp_valid_d  = 1'b0;
        busy_d       = busy_q;
        serialout_d  = 1'b0;
        rsp_rddata_d = rsp_rddata_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_QUIET: begin
                if (cnt_q == CNT_W'(QUIET - 1)) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    req_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d     = ST_SEND;
                    busy_d      = 1'b1;
                    wr_d        = req_wr;
                    serialout_d = msg[MSG_BITS-1];
                    tx_d        = msg << 1;
                    cnt_d       = CNT_W'(1);
                    acc_d       = '0;
                    rxcnt_d     = '0;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (cnt_q == tx_len) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    serialout_d = tx_q[MSG_BITS-1];
                    tx_d        = tx_q << 1;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                // A command byte takes priority over a timeout expiring in the same cycle.
                if (byte_valid && byte_flag) begin
                    state_d      = ST_RESP;
                    rsp_valid_d  = 1'b1;
                    busy_d       = 1'b0;
                    rsp_err_d    = cmd_ok ? RSP_OK : RSP_PROTO;
                    rsp_rddata_d = (cmd_ok && !wr_q) ? acc_q : 16'h0000;
                end else begin
                    if (byte_valid) begin
                        acc_d = {acc_q[7:0], byte_data};
                        if (rxcnt_q != 2'd3) begin
                            rxcnt_d = rxcnt_q + 2'd1;
                        end
                    end
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d      = ST_RESP;
                        rsp_valid_d  = 1'b1;
                        busy_d       = 1'b0;
                        rsp_err_d    = RSP_TIMEOUT;
                        rsp_rddata_d = 16'h0000;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d = ST_QUIET;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_QUIET;
            cnt_q        <= '0;
            tx_q         <= '0;
            wr_q         <= 1'b0;
            acc_q        <= '0;
            rxcnt_q      <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            serialout_q  <= 1'b0;
            rsp_rddata_q <= '0;
            rsp_err_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_q         <= tx_d;
            wr_q         <= wr_d;
            acc_q        <= acc_d;
            rxcnt_q      <= rxcnt_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            serialout_q  <= serialout_d;
            rsp_rddata_q <= rsp_rddata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rddata = rsp_rddata_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    assign serialout  = serialout_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: a behavioural register-bus target decodes the
// transmitted slots, answers on serialin, and expected responses come from a host-side model.
module tb_bus_initiator;

    localparam int TIMEOUT  = 1023;
    localparam int QUIET    = 16;
    localparam int M_OK     = 0;
    localparam int M_SILENT = 1;
    localparam int M_BADCMD = 2;
    localparam int M_SHORT  = 3;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        req_valid  = 1'b0;
    logic        req_wr     = 1'b0;
    logic [15:0] req_addr   = 16'h0000;
    logic [15:0] req_wrdata = 16'h0000;
    logic        serialin   = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rddata;
    logic [1:0]  rsp_err;
    logic        busy;
    logic        serialout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int accepts = 0;

    logic [15:0] tgt_mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];

    bus_initiator #(.TIMEOUT(TIMEOUT), .QUIET(QUIET)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wrdata (req_wrdata),
        .rsp_valid  (rsp_valid),
        .rsp_rddata (rsp_rddata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .serialout  (serialout),
        .serialin   (serialin)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && req_valid && req_ready) accepts <= accepts + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_slot(input logic flag, input logic [7:0] data);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k == 1) serialin = 1'b1;
            else if (k == 2) serialin = flag;
            else if (k >= 3 && k <= 10) serialin = data[10-k];
            else serialin = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        int quiet_n;
        int pulses;
        rst = 1'b1;
        req_valid = 1'b0;
        serialin = 1'b0;
        repeat (n) @(negedge clk);
        n_cmp++;
        if ({serialout, req_ready, rsp_valid, busy, rsp_err, rsp_rddata} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_outs: got so=%b rdy=%b vld=%b busy=%b err=%0d rd=%h, want all 0",
                     serialout, req_ready, rsp_valid, busy, rsp_err, rsp_rddata);
        end
        rst = 1'b0;
        quiet_n = 0;
        pulses = 0;
        while (req_ready !== 1'b1 && quiet_n < 200) begin
            if (rsp_valid === 1'b1) pulses++;
            quiet_n++;
            @(negedge clk);
        end
        n_cmp++;
        if (quiet_n != QUIET) begin
            n_bad++;
            $display("FAIL quiet_len: got %0d cycles with req_ready low, want %0d", quiet_n, QUIET);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL no_rsp_after_reset: got %0d rsp_valid pulses, want 0", pulses);
        end
    endtask

    task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                          input int mode, input bit hold, input logic nwr,
                          input logic [15:0] naddr, input logic [15:0] ndata, output int waited);
        logic        cap  [65];
        logic [7:0]  eb   [5];
        logic        ef   [5];
        logic [7:0]  rb   [5];
        logic        rf   [5];
        logic [7:0]  qb   [$];
        logic        qf   [$];
        logic        expb;
        logic [15:0] exp_rd;
        logic [15:0] v;
        logic [15:0] a;
        logic [1:0]  exp_err;
        int nslots, nbits, bad_bits, bad_busy, t_last, t_rsp, k;

        req_wr = wr;
        req_addr = addr;
        req_wrdata = data;
        req_valid = 1'b1;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 2000) begin
            waited++;
            @(negedge clk);
        end
        if (req_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_wait: req_ready=%b after %0d cycles, want 1", req_ready, waited);
            req_valid = 1'b0;
            return;
        end

        // Expected slot contents straight from the request.
        nslots = wr ? 5 : 3;
        nbits = nslots * 13;
        for (int s = 0; s < 5; s++) begin
            eb[s] = 8'h00;
            ef[s] = 1'b0;
        end
        if (wr) begin
            eb[0] = data[15:8]; eb[1] = data[7:0]; eb[2] = addr[15:8]; eb[3] = addr[7:0];
            eb[4] = 8'h01; ef[4] = 1'b1;
        end else begin
            eb[0] = addr[15:8]; eb[1] = addr[7:0]; eb[2] = 8'h02; ef[2] = 1'b1;
        end

        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        bad_busy = 0;
        for (int i = 0; i < nbits; i++) begin
            cap[i] = serialout;
            if (busy !== 1'b1 || req_ready !== 1'b0) bad_busy++;
            if (i < nbits - 1) @(negedge clk);
        end
        t_last = cyc;

        bad_bits = 0;
        for (int s = 0; s < nslots; s++) begin
            for (int b = 0; b < 13; b++) begin
                if (b == 1) expb = 1'b1;
                else if (b == 2) expb = ef[s];
                else if (b >= 3 && b <= 10) expb = eb[s][10-b];
                else expb = 1'b0;
                if (cap[s*13+b] !== expb) bad_bits++;
            end
        end
        n_cmp++;
        if (bad_bits != 0) begin
            n_bad++;
            $display("FAIL txbits: got %0d wrong of %0d bits (wr=%b addr=%h data=%h), want 0 wrong",
                     bad_bits, nbits, wr, addr, data);
        end
        n_cmp++;
        if (bad_busy != 0) begin
            n_bad++;
            $display("FAIL busy_send: got %0d tx cycles with busy low or req_ready high, want 0", bad_busy);
        end

        // Target model: decode what was actually received.
        for (int s = 0; s < nslots; s++) begin
            rf[s] = cap[s*13+2];
            for (int j = 0; j < 8; j++) rb[s][7-j] = cap[s*13+3+j];
        end
        exp_rd = 16'h0000;
        exp_err = 2'd0;
        if (mode == M_OK) begin
            if (nslots == 5 && rf[4] && rb[4] == 8'h01) begin
                tgt_mem[{rb[2], rb[3]}] = {rb[0], rb[1]};
                qb.push_back(8'h01); qf.push_back(1'b1);
            end else if (nslots == 3 && rf[2] && rb[2] == 8'h02) begin
                a = {rb[0], rb[1]};
                v = tgt_mem.exists(a) ? tgt_mem[a] : 16'h0000;
                qb.push_back(v[15:8]); qf.push_back(1'b0);
                qb.push_back(v[7:0]);  qf.push_back(1'b0);
                qb.push_back(8'h02);   qf.push_back(1'b1);
            end
            if (wr) ref_mem[addr] = data;
            else exp_rd = ref_mem.exists(addr) ? ref_mem[addr] : 16'h0000;
        end else if (mode == M_SILENT) begin
            exp_err = 2'd1;
        end else if (mode == M_BADCMD) begin
            qb.push_back(8'h01); qf.push_back(1'b1);
            exp_err = 2'd2;
        end else begin
            qb.push_back(8'($urandom)); qf.push_back(1'b0);
            qb.push_back(8'h02);        qf.push_back(1'b1);
            exp_err = 2'd2;
        end

        repeat ($urandom_range(0, 3)) @(negedge clk);
        foreach (qb[i]) send_slot(qf[i], qb[i]);
        @(negedge clk);
        serialin = 1'b0;

        k = 0;
        while (rsp_valid !== 1'b1 && k < TIMEOUT + 200) begin
            k++;
            @(negedge clk);
        end
        t_rsp = cyc;
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, want 1", rsp_valid, k);
            req_valid = 1'b0;
            return;
        end
        n_cmp++;
        if (rsp_err !== exp_err) begin
            n_bad++;
            $display("FAIL rsp_err: got %0d, want %0d (wr=%b addr=%h mode=%0d)", rsp_err, exp_err, wr, addr, mode);
        end
        n_cmp++;
        if (rsp_rddata !== exp_rd) begin
            n_bad++;
            $display("FAIL rsp_rddata: got %h, want %h (wr=%b addr=%h mode=%0d)", rsp_rddata, exp_rd, wr, addr, mode);
        end
        if (mode == M_SILENT) begin
            n_cmp++;
            if (t_rsp - t_last != TIMEOUT + 1) begin
                n_bad++;
                $display("FAIL timeout_latency: got %0d cycles, want %0d", t_rsp - t_last, TIMEOUT + 1);
            end
        end
        if (hold) begin
            req_wr = nwr;
            req_addr = naddr;
            req_wrdata = ndata;
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL pulse_end: got rsp_valid=%b busy=%b after response, want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        do_reset(3);
    endtask

    task automatic test_write();
        int w;
        do_txn(1'b1, 16'h1234, 16'hBEEF, M_OK, 1'b0, 1'b0, 16'h0, 16'h0, w);
    endtask

    task automatic test_read();
        int w;
        tgt_mem[16'h0042] = 16'hA5C3;
        ref_mem[16'h0042] = 16'hA5C3;
        do_txn(1'b0, 16'h0042, 16'h0000, M_OK, 1'b0, 1'b0, 16'h0, 16'h0, w);
    endtask

    task automatic test_timeout();
        int w;
        do_txn(1'b0, 16'h0042, 16'h0000, M_SILENT, 1'b0, 1'b0, 16'h0, 16'h0, w);
    endtask

    task automatic test_proto();
        int w;
        do_txn(1'b0, 16'h0042, 16'h0000, M_BADCMD, 1'b0, 1'b0, 16'h0, 16'h0, w);
        do_txn(1'b0, 16'h0042, 16'h0000, M_SHORT, 1'b0, 1'b0, 16'h0, 16'h0, w);
    endtask

    task automatic test_reset_mid_send();
        int w;
        req_wr = 1'b1;
        req_addr = 16'h0BAD;
        req_wrdata = 16'h5555;
        req_valid = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 2000) begin
            w++;
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (19) @(negedge clk);
        do_reset(1);
        do_txn(1'b0, 16'h1234, 16'h0000, M_OK, 1'b0, 1'b0, 16'h0, 16'h0, w);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a0, a1, d0, d1;
        int w, acc0;
        a0 = 16'($urandom);
        a1 = a0 ^ 16'h0100;
        d0 = 16'($urandom);
        d1 = 16'($urandom);
        acc0 = accepts;
        do_txn(1'b1, a0, d0, M_OK, 1'b1, 1'b0, a0, 16'h0, w);
        do_txn(1'b0, a0, 16'h0, M_OK, 1'b1, 1'b1, a1, d1, w);
        n_cmp++;
        if (w != 0) begin
            n_bad++;
            $display("FAIL b2b_gap1: got %0d extra idle cycles before accept, want 0", w);
        end
        do_txn(1'b1, a1, d1, M_OK, 1'b1, 1'b0, a1, 16'h0, w);
        n_cmp++;
        if (w != 0) begin
            n_bad++;
            $display("FAIL b2b_gap2: got %0d extra idle cycles before accept, want 0", w);
        end
        do_txn(1'b0, a1, 16'h0, M_OK, 1'b0, 1'b0, 16'h0, 16'h0, w);
        n_cmp++;
        if (w != 0) begin
            n_bad++;
            $display("FAIL b2b_gap3: got %0d extra idle cycles before accept, want 0", w);
        end
        n_cmp++;
        if (accepts - acc0 != 4) begin
            n_bad++;
            $display("FAIL b2b_accepts: got %0d accepts, want 4", accepts - acc0);
        end
    endtask

    task automatic test_random();
        logic [15:0] pool [4];
        int w;
        pool[0] = 16'h0042; pool[1] = 16'h1234; pool[2] = 16'h00F0; pool[3] = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            do_txn(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], 16'($urandom),
                   M_OK, 1'b0, 1'b0, 16'h0, 16'h0, w);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_proto();
        test_reset_mid_send();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_initiator.md
Name: bus_initiator

Overview:
- Host-side initiator for the 16A/16D serial register bus: accepts one read or write request at a time and serializes it as framed bytes to the target bus FSM's serial input.
- Deframes the target's serial reply and returns read data or an error code.
- Sits between a local controller (DMA/config sequencer) and the serial link to a register-bus target.

Parameters:
- TIMEOUT, 1023: cycles to wait, after the last transmitted bit, for the reply command byte before declaring a timeout.
- QUIET, 16: cycles serialout is held 0 after reset before the first request is accepted. Must be at least 13.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  initiator can accept a request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  16  register address
- req_wrdata  in  16  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse: transaction complete
- rsp_rddata  out  16  read data; 0 for writes and on error
- rsp_err  out  2  0 = ok, 1 = timeout, 2 = protocol error
- busy  out  1  transaction in progress
- serialout  out  1  to target serial input
- serialin  in  1  from target serial output

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: serialout=0, req_ready=0, rsp_valid=0, rsp_rddata=0, rsp_err=0, busy=0. State=QUIET.
- Reset mid-transaction aborts the transaction with no response pulse. serialout is 0 from the next cycle.
- Frame slot is 13 bits, sent MSb first: 0 (idle), 1 (start), F (1 = command byte), d7..d0, 0, 0 (stop). The leading idle bit gives the target receiver the one dead cycle it needs after each frame.
- Write message: 5 slots. Data bytes (F=0) wrdata[15:8], wrdata[7:0], addr[15:8], addr[7:0], then command byte 0x01 (F=1).
- Read message: 3 slots. Data bytes addr[15:8], addr[7:0], then command byte 0x02.
- Handshake: transfer occurs on req_valid && req_ready. req_ready=1 only in IDLE. Request fields are latched on the accept cycle.
- FSM states: QUIET, IDLE, SEND, WAIT, RESP.
  - QUIET: count QUIET cycles, then go to IDLE.
  - IDLE: on accept, go to SEND; busy=1 from the next cycle.
  - SEND: the first slot bit appears on serialout the cycle after accept. Go to WAIT after 65 bits (write) or 39 bits (read).
  - WAIT: timeout counter cleared on entry. Decoded reply bytes processed as described below. When the counter reaches TIMEOUT with no command byte, set rsp_err=1 and go to RESP.
  - RESP: rsp_valid=1 for one cycle, busy=0, then IDLE. rsp_rddata and rsp_err hold until the next RESP.
- Reply deframer: 12-bit shift register, serialin shifted into the LSb.
  - A byte is detected when bit11=1 and bits[1:0]=00. On detection, take F=bit10 and data=bits[9:2], and clear the register.
  - Bytes decoded outside WAIT are discarded.
- Reply parsing in WAIT:
  - Data bytes (F=0) shift into a 16-bit accumulator and increment a count.
  - On a command byte (F=1), go to RESP.
  - Read: ok iff cmd=0x02 and count=2. rsp_rddata = accumulator.
  - Write: ok iff cmd=0x01 and count=0.
  - Otherwise rsp_err=2 and rsp_rddata=0.
- Simultaneous timeout expiry and command-byte detection: the command byte wins.
- Back-to-back requests: a request asserted during RESP is accepted in the following IDLE cycle. There are no idle bits beyond the slot's leading 0.

Decomposition:
- Shared package (bus_pkg) holds:
  - CMD_WRITE=8'h01, CMD_READ=8'h02
  - SLOT_BITS=13, FRAME_BITS=12
  - RSP_OK/RSP_TIMEOUT/RSP_PROTO codes
  - FSM state enumeration
- One sub-module: bus_deframer (serialin → byte_valid, byte_flag, byte_data[7:0]; synchronous clear). Reusable by any serial-bus endpoint.

Test Plan:
- Reset then write: rst high 3 cycles; req_ready stays 0 for QUIET=16 cycles. Request write addr=0x1234, data=0xBEEF against a model target. Required:
  - serialout bitstream = slots BE, EF, 12, 34, cmd 01; 65 bits; first bit the cycle after accept.
  - rsp_valid once with err=0 and rddata=0.
- Read: model register 0x0042 = 0xA5C3. Read addr=0x0042. Required:
  - 39 bits sent.
  - rsp_rddata=0xA5C3, err=0.
  - busy low the cycle after rsp_valid.
- Timeout: serialin tied 0, read issued. Required: rsp_valid exactly TIMEOUT+1 cycles after the last tx bit, err=1, rddata=0.
- Protocol error: target replies cmd 0x01 to a read, then separately replies 1 data byte + cmd 0x02. Required: err=2 and rddata=0 in both cases.
- Reset mid-SEND: assert rst after 20 bits of a write. Required:
  - serialout=0 the next cycle; no rsp_valid.
  - After QUIET, a fresh read completes with err=0.
- Back-to-back: 4 alternating writes/reads with req_valid held high. Required:
  - Each accepted exactly once, with no overlap.
  - Read data matches the previously written values.
